// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared types and constants for the external async-memory arbiter.
//   state_e  : access sequencer states (IDLE, ACCESS, ACK)
//   REQ_CPU  : requester id of the CPU-side port (m0)
//   REQ_DBG  : requester id of the loader/debug port (m1)
//   AW_DEF / DW_DEF / WAIT_DEF : default address width, data width, wait cycles
//   CNT_W    : width of the wait counter (holds WAIT values 0..15)
// -----------------------------------------------------------------------------
package mem_bus_pkg;

    localparam int AW_DEF   = 16;
    localparam int DW_DEF   = 8;
    localparam int WAIT_DEF = 2;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/mem_rr_arb.sv
// -----------------------------------------------------------------------------
// mem_rr_arb
// Two-way round-robin picker, purely combinational. The "last granted"
// register is owned by the parent so the grant only advances when the
// parent actually starts an access.
//   req       in  [1:0] request lines, bit 0 = CPU, bit 1 = debug
//   last      in        id of the most recently granted requester
//   gnt_id    out       id of the winner (valid when gnt_valid is high)
//   gnt_valid out       at least one request is pending
// -----------------------------------------------------------------------------
module mem_rr_arb
    import mem_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_id,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = REQ_CPU;
        if (req == 2'b11) begin
            // Under contention the requester that was not served last wins,
            // which makes grants strictly alternate.
            gnt_id = ~last;
        end else if (req[1]) begin
            gnt_id = REQ_DBG;
        end
    end

endmodule

// File: rtl/mem_bus_arb.sv
// -----------------------------------------------------------------------------
// mem_bus_arb
// Arbitrates two requesters onto one asynchronous memory bus. A granted
// access holds select/address/data/write strobe for WAIT+1 cycles, captures
// read data at the end of that window, then pulses the winner's ack for one
// cycle before returning to IDLE. Every output comes straight from a flop.
//   clk                  in   system clock, rising edge
//   reset                in   synchronous, active-high reset
//   m0_req/m0_we         in   CPU-side request / write enable
//   m0_addr/m0_wdata     in   CPU-side address / write data
//   m0_ack/m0_rdata      out  CPU-side completion pulse / read data
//   m1_*                      same set for the loader/debug requester
//   mem_sel/mem_we       out  memory select / write strobe
//   mem_a/mem_dout       out  memory address / write data
//   mem_din              in   asynchronous read data from memory
//   busy                 out  sequencer is not IDLE
// -----------------------------------------------------------------------------
module mem_bus_arb
    import mem_bus_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int WAIT = WAIT_DEF   // legal range 0..15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_sel,
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [DW-1:0] mem_dout,
    input  logic [DW-1:0] mem_din,
    output logic          busy
);

    state_e             state_q,    state_d;
    logic               last_q,     last_d;
    logic               id_q,       id_d;
    logic               we_q,       we_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               mem_sel_q,  mem_sel_d;
    logic               mem_we_q,   mem_we_d;
    logic [AW-1:0]      mem_a_q,    mem_a_d;
    logic [DW-1:0]      mem_dout_q, mem_dout_d;
    logic               m0_ack_q,   m0_ack_d;
    logic               m1_ack_q,   m1_ack_d;
    logic [DW-1:0]      m0_rdata_q, m0_rdata_d;
    logic [DW-1:0]      m1_rdata_q, m1_rdata_d;
    logic               busy_q,     busy_d;

    logic [1:0]         req_vec;
    logic               gnt_id;
    logic               gnt_valid;

    assign req_vec = {m1_req, m0_req};

    mem_rr_arb u_arb (
        .req       (req_vec),
        .last      (last_q),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        // NOTE: every next-state signal takes its current value first, so no
        // branch can leave one unassigned and no latch is inferred.
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    // The address/data registers double as the latched request,
                    // so later changes on the requester side are ignored.
                    id_d    = gnt_id;
                    last_d  = gnt_id;
                    cnt_d   = CNT_W'(WAIT);
                    state_d = ACCESS;
                    if (gnt_id == REQ_DBG) begin
                        we_d       = m1_we;
                        mem_a_d    = m1_addr;
                        mem_dout_d = m1_wdata;
                    end else begin
                        we_d       = m0_we;
                        mem_a_d    = m0_addr;
                        mem_dout_d = m0_wdata;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (id_q == REQ_DBG) begin
                            m1_rdata_d = mem_din;
                        end else begin
                            m0_rdata_d = mem_din;
                        end
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are derived from the next state so they leave a flop in the
        // same cycle the sequencer enters that state.
        mem_sel_d = (state_d == ACCESS);
        mem_we_d  = (state_d == ACCESS) && we_d;
        busy_d    = (state_d != IDLE);
        m0_ack_d  = (state_d == ACK) && (id_d == REQ_CPU);
        m1_ack_d  = (state_d == ACK) && (id_d == REQ_DBG);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments only, so every
        // flop samples the values that existed before the edge.
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= REQ_DBG;     // m0 wins the first contention
            id_q       <= REQ_CPU;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            mem_sel_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            id_q       <= id_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            mem_sel_q  <= mem_sel_d;
            mem_we_q   <= mem_we_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign mem_sel  = mem_sel_q;
    assign mem_we   = mem_we_q;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arb
// Self-checking bench for mem_bus_arb. A WAIT=2 instance is the main target;
// a WAIT=0 instance shares the same stimulus for the zero-wait case. Each
// instance has a 256-byte memory stub decoded on mem_a[7:0].
// -----------------------------------------------------------------------------
module tb_mem_bus_arb;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int WT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;

    logic          m0_ack, m1_ack, mem_sel, mem_we, busy;
    logic [DW-1:0] m0_rdata, m1_rdata, mem_dout, mem_din;
    logic [AW-1:0] mem_a;

    logic          z_m0_ack, z_m1_ack, z_mem_sel, z_mem_we, z_busy;
    logic [DW-1:0] z_m0_rdata, z_m1_rdata, z_mem_dout, z_mem_din;
    logic [AW-1:0] z_mem_a;

    logic [7:0]    ram  [256];
    logic [7:0]    zram [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bus_arb #(.AW(AW), .DW(DW), .WAIT(WT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_sel(mem_sel), .mem_a(mem_a), .mem_we(mem_we), .mem_dout(mem_dout),
        .mem_din(mem_din), .busy(busy)
    );

    mem_bus_arb #(.AW(AW), .DW(DW), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(z_m0_ack), .m0_rdata(z_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(z_m1_ack), .m1_rdata(z_m1_rdata),
        .mem_sel(z_mem_sel), .mem_a(z_mem_a), .mem_we(z_mem_we), .mem_dout(z_mem_dout),
        .mem_din(z_mem_din), .busy(z_busy)
    );

    // ROM image in the low locations; everything else is a recognisable pattern.
    function automatic logic [7:0] init_val(input int i);
        case (i)
            0:       return 8'h4F;
            2:       return 8'h86;
            3:       return 8'hFF;
            254:     return 8'hFF;
            default: return 8'(i * 7 + 3);
        endcase
    endfunction

    assign mem_din   = ram[mem_a[7:0]];
    assign z_mem_din = zram[z_mem_a[7:0]];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                ram[i]  <= init_val(i);
                zram[i] <= init_val(i);
            end
        end else begin
            if (mem_sel && mem_we)     ram[mem_a[7:0]]    <= mem_dout;
            if (z_mem_sel && z_mem_we) zram[z_mem_a[7:0]] <= z_mem_dout;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Single-transaction table: expected rdata is the requester's rdata after ack.
    typedef struct {
        logic          id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] rd_exp [2];

    task automatic run_txn(input int idx, input vec_t v);
        if (v.id) begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
        end else begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
        end
        for (int c = 0; c <= WT + 2; c++) begin
            tick();
            check($sformatf("v%0d_c%0d_sel", idx, c), mem_sel, c <= WT);
            check($sformatf("v%0d_c%0d_busy", idx, c), busy, c <= WT + 1);
            check($sformatf("v%0d_c%0d_ack0", idx, c), m0_ack, (c == WT + 1) && !v.id);
            check($sformatf("v%0d_c%0d_ack1", idx, c), m1_ack, (c == WT + 1) && v.id);
            if (c <= WT) begin
                check($sformatf("v%0d_c%0d_addr", idx, c), mem_a, v.addr);
                check($sformatf("v%0d_c%0d_we", idx, c), mem_we, v.we);
                if (v.we) check($sformatf("v%0d_c%0d_dout", idx, c), mem_dout, v.wdata);
            end
            if (c == 0) begin
                // Scramble the request fields after the grant; they must be ignored.
                if (v.id) begin
                    m1_we = ~v.we; m1_addr = ~v.addr; m1_wdata = ~v.wdata;
                end else begin
                    m0_we = ~v.we; m0_addr = ~v.addr; m0_wdata = ~v.wdata;
                end
            end
            if (c == WT + 1) begin
                rd_exp[v.id] = v.exp_rdata;
                check($sformatf("v%0d_rdata0", idx), m0_rdata, rd_exp[0]);
                check($sformatf("v%0d_rdata1", idx), m1_rdata, rd_exp[1]);
                clear_inputs();
            end
        end
    endtask

    // Reference model state for the random phase (transaction/time based).
    int          n, g;
    logic        mlast, gid, gwe, win, out0, out1;
    logic [15:0] gaddr;
    logic [7:0]  gwdata;
    logic [7:0]  exp_rd [2];
    logic [7:0]  ref_mem [256];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ack0_c, ack1_c, seen, first_c;
        logic exp_id, first_id;

        vecs[0] = '{id: 1'b0, we: 1'b0, addr: 16'h0000, wdata: 8'h00, exp_rdata: 8'h4F};
        vecs[1] = '{id: 1'b1, we: 1'b0, addr: 16'h00FE, wdata: 8'h00, exp_rdata: 8'hFF};
        vecs[2] = '{id: 1'b1, we: 1'b1, addr: 16'h0010, wdata: 8'hA5, exp_rdata: 8'hFF};
        vecs[3] = '{id: 1'b0, we: 1'b0, addr: 16'h0010, wdata: 8'h00, exp_rdata: 8'hA5};
        vecs[4] = '{id: 1'b0, we: 1'b1, addr: 16'h1234, wdata: 8'h3C, exp_rdata: 8'hA5};
        vecs[5] = '{id: 1'b1, we: 1'b0, addr: 16'hAB34, wdata: 8'h00, exp_rdata: 8'h3C};

        do_reset();

        // Reset state
        check("rst_sel", mem_sel, 0);
        check("rst_we", mem_we, 0);
        check("rst_a", mem_a, 0);
        check("rst_dout", mem_dout, 0);
        check("rst_busy", busy, 0);
        check("rst_ack0", m0_ack, 0);
        check("rst_ack1", m1_ack, 0);
        check("rst_rd0", m0_rdata, 0);
        check("rst_rd1", m1_rdata, 0);
        check("rst_z_sel", z_mem_sel, 0);
        check("rst_z_busy", z_busy, 0);

        // Table-driven single transactions
        rd_exp[0] = 8'h00;
        rd_exp[1] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            run_txn(i, vecs[i]);
        end

        // Contention in the same cycle: m0 first, then m1 after an IDLE cycle
        do_reset();
        m0_req = 1'b1; m0_addr = 16'h0002;
        m1_req = 1'b1; m1_addr = 16'h0003;
        ack0_c = -1; ack1_c = -1;
        for (int c = 0; c < 16; c++) begin
            tick();
            check("cont_double", m0_ack && m1_ack, 0);
            check($sformatf("cont_busy_c%0d", c), busy,
                  (c <= WT + 1) || (c >= WT + 3 && c <= 2 * WT + 4));
            if (m0_ack && ack0_c < 0) begin ack0_c = c; m0_req = 1'b0; end
            if (m1_ack && ack1_c < 0) begin ack1_c = c; m1_req = 1'b0; end
        end
        check("cont_ack0_cycle", ack0_c, WT + 1);
        check("cont_ack1_cycle", ack1_c, 2 * WT + 4);
        check("cont_rd0", m0_rdata, 8'h86);
        check("cont_rd1", m1_rdata, 8'hFF);

        // Continuous contention: grants alternate starting with m0
        do_reset();
        m0_req = 1'b1; m0_addr = 16'h0000;
        m1_req = 1'b1; m1_addr = 16'h0003;
        seen = 0; exp_id = 1'b0;
        for (int c = 0; c < 60 && seen < 6; c++) begin
            tick();
            check("alt_double", m0_ack && m1_ack, 0);
            if (m0_ack || m1_ack) begin
                check($sformatf("alt_grant%0d", seen), m1_ack, exp_id);
                exp_id = ~exp_id;
                seen++;
            end
        end
        check("alt_count", seen, 6);

        // Zero-wait instance, request dropped right after the grant
        do_reset();
        m1_req = 1'b1; m1_addr = 16'h00FE;
        for (int c = 0; c <= WT + 2; c++) begin
            tick();
            check($sformatf("w0_sel_c%0d", c), z_mem_sel, c == 0);
            check($sformatf("w0_ack1_c%0d", c), z_m1_ack, c == 1);
            check($sformatf("w0_ack0_c%0d", c), z_m0_ack, 0);
            check($sformatf("w0_busy_c%0d", c), z_busy, c <= 1);
            check($sformatf("drop_ack1_c%0d", c), m1_ack, c == WT + 1);
            if (c == 0) begin
                check("w0_addr", z_mem_a, 16'h00FE);
                m1_req = 1'b0;
            end
            if (c == 1) check("w0_rd1", z_m1_rdata, 8'hFF);
        end

        // Reset in the second ACCESS cycle aborts the access
        do_reset();
        m0_req = 1'b1; m0_addr = 16'h0000;
        m1_req = 1'b1; m1_addr = 16'h0003;
        tick();
        tick();
        check("abort_sel_before", mem_sel, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_sel", mem_sel, 0);
        check("abort_we", mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_ack", m0_ack || m1_ack, 0);
        first_c = -1; first_id = 1'b0;
        for (int c = 0; c < 12 && first_c < 0; c++) begin
            tick();
            if (m0_ack || m1_ack) begin
                first_c = c;
                first_id = m1_ack;
            end
        end
        check("abort_first_cycle", first_c, WT + 1);
        check("abort_first_id", first_id, 0);

        // Random stimulus against the reference model
        do_reset();
        n = 0; g = -1000; mlast = 1'b1; gid = 1'b0; gwe = 1'b0;
        gaddr = '0; gwdata = '0; exp_rd[0] = '0; exp_rd[1] = '0;
        out0 = 1'b0; out1 = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            // A new grant is possible once the previous access, its ack cycle
            // and the following IDLE cycle are over.
            if (n >= g + WT + 3 && (m0_req || m1_req)) begin
                win    = (m0_req && m1_req) ? ~mlast : m1_req;
                mlast  = win;
                g      = n;
                gid    = win;
                gwe    = win ? m1_we    : m0_we;
                gaddr  = win ? m1_addr  : m0_addr;
                gwdata = win ? m1_wdata : m0_wdata;
            end
            if (n == g + WT + 1) begin
                if (gwe) ref_mem[gaddr[7:0]] = gwdata;
                else     exp_rd[gid] = ref_mem[gaddr[7:0]];
            end
            tick();
            check("rnd_sel", mem_sel, n >= g && n <= g + WT);
            check("rnd_we", mem_we, (n >= g && n <= g + WT) && gwe);
            check("rnd_busy", busy, n >= g && n <= g + WT + 1);
            check("rnd_ack0", m0_ack, (n == g + WT + 1) && !gid);
            check("rnd_ack1", m1_ack, (n == g + WT + 1) && gid);
            check("rnd_addr", mem_a, gaddr);
            check("rnd_dout", mem_dout, gwdata);
            check("rnd_rd0", m0_rdata, exp_rd[0]);
            check("rnd_rd1", m1_rdata, exp_rd[1]);
            n++;

            if (m0_ack) out0 = 1'b0;
            if (m1_ack) out1 = 1'b0;
            if (!out0 && $urandom_range(0, 2) == 0) out0 = 1'b1;
            if (!out1 && $urandom_range(0, 2) == 0) out1 = 1'b1;
            m0_req = out0;
            m1_req = out1;
            if (m0_req && $urandom_range(0, 1) == 1) begin
                m0_we    = 1'($urandom_range(0, 1));
                m0_addr  = {8'($urandom_range(0, 255)), 8'(8'h10 + $urandom_range(0, 7))};
                m0_wdata = 8'($urandom_range(0, 255));
            end
            if (m1_req && $urandom_range(0, 1) == 1) begin
                m1_we    = 1'($urandom_range(0, 1));
                m1_addr  = {8'($urandom_range(0, 255)), 8'(8'h10 + $urandom_range(0, 7))};
                m1_wdata = 8'($urandom_range(0, 255));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
